// File: rtl/sar_seq_pkg.sv
// Shared types and defaults for the SAR conversion sequencer.
// The accumulator carries 3 guard bits so eight full-scale results sum without overflow.
package sar_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_SETTLE,
        ST_CONVERT,
        ST_ACCUM
    } seq_state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_NCH        = 4;
    localparam int DEF_SAMPLE_CYC = 4;
    localparam int DEF_SETTLE_CYC = 1;
    localparam int DEF_TIMEOUT    = 16;
    localparam int ACC_GUARD      = 3;
    localparam int ACC_W          = DEF_WIDTH + ACC_GUARD;

    function automatic int acc_width(input int width);
        return width + ACC_GUARD;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sar_ch_picker.sv
// Finds the next set bit of the channel mask strictly above cur, wrapping to bit 0.
// wrapped flags that the search passed the top channel, i.e. cur was the last one of a pass.
module sar_ch_picker #(
    parameter int NCH  = 4,
    parameter int CH_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]  mask,
    input  logic [CH_W-1:0] cur,
    output logic [CH_W-1:0] next_ch,
    output logic            wrapped
);

    logic [NCH-1:0] rot_mask;
    int             offset;
    int             pos;
    logic           found;

    // rot_mask[0] is the channel just above cur, rot_mask[NCH-1] is cur itself
    for (genvar gi = 0; gi < NCH; gi++) begin : g_rot
        assign rot_mask[gi] = mask[CH_W'((int'(cur) + gi + 1) % NCH)];
    end

    always_comb begin
        offset = 0;
        found  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && rot_mask[k]) begin
                found  = 1'b1;
                offset = k;
            end
        end
        pos     = int'(cur) + offset + 1;
        wrapped = (pos >= NCH);
        next_ch = CH_W'(pos % NCH);
    end

endmodule

// File: rtl/sar_conv_sequencer.sv
// Drives track/hold and start timing for the SAR core, scans enabled channels,
// averages 2^avg conversions per channel and presents results through a one-deep register.
module sar_conv_sequencer
    import sar_seq_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int NCH        = DEF_NCH,
    parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_en,
    input  logic                     cfg_cont,
    input  logic [NCH-1:0]           cfg_ch_mask,
    input  logic [1:0]               cfg_avg_log2,
    input  logic                     trig,
    input  logic                     ovr_clr,
    output logic                     sample_en,
    output logic [$clog2(NCH)-1:0]   ch_sel,
    output logic                     sar_start,
    input  logic                     sar_done,
    input  logic [WIDTH-1:0]         sar_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [$clog2(NCH)-1:0]   res_ch,
    output logic                     busy,
    output logic                     overrun,
    output logic                     timeout_err
);

    localparam int CH_W  = $clog2(NCH);
    localparam int SUM_W = acc_width(WIDTH);
    localparam int TMR_W = $clog2(max3(SAMPLE_CYC, SETTLE_CYC, TIMEOUT) + 1);
    localparam logic [TMR_W-1:0] SAMPLE_LAST  = TMR_W'(SAMPLE_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT);

    seq_state_t        state_reg;
    logic              sample_en_reg;
    logic              sar_start_reg;
    logic [CH_W-1:0]   ch_sel_reg;
    logic [TMR_W-1:0]  tmr_reg;
    logic [2:0]        conv_cnt_reg;
    logic [1:0]        avg_reg;
    logic [SUM_W-1:0]  acc_reg;
    logic [WIDTH-1:0]  result_reg;
    logic              res_valid_reg;
    logic [WIDTH-1:0]  res_data_reg;
    logic [CH_W-1:0]   res_ch_reg;
    logic              overrun_reg;
    logic              timeout_err_reg;

    logic [CH_W-1:0]   pick_cur;
    logic [CH_W-1:0]   pick_next;
    logic              pick_wrapped;
    logic [SUM_W-1:0]  acc_sum;
    logic [3:0]        conv_total;
    logic              conv_final;

    // From IDLE the search starts above the top channel, yielding the lowest set bit
    assign pick_cur   = (state_reg == ST_IDLE) ? CH_W'(NCH - 1) : ch_sel_reg;
    assign acc_sum    = acc_reg + SUM_W'(result_reg);
    assign conv_total = 4'd1 << avg_reg;
    assign conv_final = ({1'b0, conv_cnt_reg} == (conv_total - 4'd1));

    sar_ch_picker #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_picker (
        .mask    (cfg_ch_mask),
        .cur     (pick_cur),
        .next_ch (pick_next),
        .wrapped (pick_wrapped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            sample_en_reg   <= 1'b0;
            sar_start_reg   <= 1'b0;
            ch_sel_reg      <= '0;
            tmr_reg         <= '0;
            conv_cnt_reg    <= '0;
            avg_reg         <= '0;
            acc_reg         <= '0;
            result_reg      <= '0;
            res_valid_reg   <= 1'b0;
            res_data_reg    <= '0;
            res_ch_reg      <= '0;
            overrun_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            sar_start_reg <= 1'b0;
            if (res_valid_reg && res_ready) begin
                res_valid_reg <= 1'b0;
            end
            if (ovr_clr) begin
                overrun_reg <= 1'b0;
            end

            if (!cfg_en) begin
                state_reg     <= ST_IDLE;
                sample_en_reg <= 1'b0;
                tmr_reg       <= '0;
                conv_cnt_reg  <= '0;
                acc_reg       <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (trig && (|cfg_ch_mask)) begin
                            state_reg       <= ST_SAMPLE;
                            sample_en_reg   <= 1'b1;
                            ch_sel_reg      <= pick_next;
                            avg_reg         <= cfg_avg_log2;
                            tmr_reg         <= '0;
                            conv_cnt_reg    <= '0;
                            acc_reg         <= '0;
                            timeout_err_reg <= 1'b0;
                        end
                    end
                    ST_SAMPLE: begin
                        if (tmr_reg == SAMPLE_LAST) begin
                            sample_en_reg <= 1'b0;
                            tmr_reg       <= '0;
                            if (SETTLE_CYC == 0) begin
                                state_reg     <= ST_CONVERT;
                                sar_start_reg <= 1'b1;
                            end else begin
                                state_reg <= ST_SETTLE;
                            end
                        end else begin
                            tmr_reg <= tmr_reg + TMR_W'(1);
                        end
                    end
                    ST_SETTLE: begin
                        if (tmr_reg == SETTLE_LAST) begin
                            state_reg     <= ST_CONVERT;
                            sar_start_reg <= 1'b1;
                            tmr_reg       <= '0;
                        end else begin
                            tmr_reg <= tmr_reg + TMR_W'(1);
                        end
                    end
                    ST_CONVERT: begin
                        if (sar_done) begin
                            result_reg <= sar_result;
                            state_reg  <= ST_ACCUM;
                            tmr_reg    <= '0;
                        end else if (tmr_reg == TIMEOUT_LAST) begin
                            timeout_err_reg <= 1'b1;
                            state_reg       <= ST_IDLE;
                            tmr_reg         <= '0;
                            conv_cnt_reg    <= '0;
                            acc_reg         <= '0;
                        end else begin
                            tmr_reg <= tmr_reg + TMR_W'(1);
                        end
                    end
                    ST_ACCUM: begin
                        tmr_reg <= '0;
                        if (conv_final) begin
                            res_valid_reg <= 1'b1;
                            res_data_reg  <= WIDTH'(acc_sum >> avg_reg);
                            res_ch_reg    <= ch_sel_reg;
                            if (res_valid_reg && !res_ready) begin
                                overrun_reg <= 1'b1;
                            end
                            acc_reg      <= '0;
                            conv_cnt_reg <= '0;
                            // Live mask decides where the scan goes after a finished channel
                            if (!(|cfg_ch_mask) || (!cfg_cont && pick_wrapped)) begin
                                state_reg <= ST_IDLE;
                            end else begin
                                state_reg     <= ST_SAMPLE;
                                sample_en_reg <= 1'b1;
                                ch_sel_reg    <= pick_next;
                                avg_reg       <= cfg_avg_log2;
                            end
                        end else begin
                            acc_reg       <= acc_sum;
                            conv_cnt_reg  <= conv_cnt_reg + 3'd1;
                            state_reg     <= ST_SAMPLE;
                            sample_en_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg     <= ST_IDLE;
                        sample_en_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sample_en   = sample_en_reg;
    assign ch_sel      = ch_sel_reg;
    assign sar_start   = sar_start_reg;
    assign res_valid   = res_valid_reg;
    assign res_data    = res_data_reg;
    assign res_ch      = res_ch_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign overrun     = overrun_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Bench for sar_conv_sequencer: behavioural SAR core with random latency and values,
// per-scan expected results computed from mask order and plain averaging.
module tb_sar_conv_sequencer;

    localparam int W          = 8;
    localparam int NCH        = 4;
    localparam int CH_W       = 2;
    localparam int SAMPLE_CYC = 4;
    localparam int SETTLE_CYC = 1;
    localparam int TIMEOUT    = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_en = 1'b0;
    logic            cfg_cont = 1'b0;
    logic [NCH-1:0]  cfg_ch_mask = '0;
    logic [1:0]      cfg_avg_log2 = '0;
    logic            trig = 1'b0;
    logic            ovr_clr = 1'b0;
    logic            sample_en;
    logic [CH_W-1:0] ch_sel;
    logic            sar_start;
    logic            sar_done = 1'b0;
    logic [W-1:0]    sar_result = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [W-1:0]    res_data;
    logic [CH_W-1:0] res_ch;
    logic            busy;
    logic            overrun;
    logic            timeout_err;

    sar_conv_sequencer #(
        .WIDTH      (W),
        .NCH        (NCH),
        .SAMPLE_CYC (SAMPLE_CYC),
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_en       (cfg_en),
        .cfg_cont     (cfg_cont),
        .cfg_ch_mask  (cfg_ch_mask),
        .cfg_avg_log2 (cfg_avg_log2),
        .trig         (trig),
        .ovr_clr      (ovr_clr),
        .sample_en    (sample_en),
        .ch_sel       (ch_sel),
        .sar_start    (sar_start),
        .sar_done     (sar_done),
        .sar_result   (sar_result),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_ch       (res_ch),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_done  = 0;
    int core_cnt = 0;
    int core_v;
    bit core_hang = 1'b0;
    int prog_q[$];
    int conv_vals[$];
    int got_ch[$];
    int got_data[$];
    int cyc = 0;
    int done_cyc = 0;
    int lat_dv = -1;
    logic valid_prev = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // SAR core model: done 1..4 cycles after start, value from prog_q or random
    always @(posedge clk) begin
        #1;
        sar_done = 1'b0;
        if (!rst_n) begin
            core_cnt = 0;
        end else begin
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_v = (prog_q.size() > 0) ? prog_q.pop_front() : int'($urandom_range(0, 255));
                    sar_done   = 1'b1;
                    sar_result = W'(core_v);
                    conv_vals.push_back(core_v);
                    n_done++;
                end
            end
            if (sar_start) begin
                n_start++;
                if (!core_hang) core_cnt = int'($urandom_range(1, 4));
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (sar_done) done_cyc = cyc;
        if (res_valid && !valid_prev) lat_dv = cyc - done_cyc;
        valid_prev = res_valid;
        if (res_valid && res_ready) begin
            got_ch.push_back(int'(res_ch));
            got_data.push_back(int'(res_data));
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_trig;
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic wait_start(output int lat);
        lat = 1;
        while (!sar_start && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_scan(input logic [NCH-1:0] mask, input int avg);
        int lat, guard, s0, n, idx, k, sum;
        cfg_ch_mask  = mask;
        cfg_avg_log2 = 2'(avg);
        cfg_cont     = 1'b0;
        res_ready    = 1'b1;
        conv_vals.delete();
        got_ch.delete();
        got_data.delete();
        s0     = n_start;
        lat_dv = -1;
        pulse_trig();
        wait_start(lat);
        check("trig_to_start", lat, SAMPLE_CYC + 2);
        guard = 0;
        while (busy && guard < 3000) begin
            tick();
            guard++;
        end
        check("scan_end_busy", int'(busy), 0);
        repeat (3) tick();
        check("done_to_valid", lat_dv, 2);
        n = 1 << avg;
        idx = 0;
        k = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (mask[ch]) begin
                sum = 0;
                for (int j = 0; j < n; j++) begin
                    if (idx < conv_vals.size()) sum += conv_vals[idx];
                    idx++;
                end
                if (k < got_ch.size()) begin
                    check("res_ch", got_ch[k], ch);
                    check("res_data", got_data[k], sum >> avg);
                end
                k++;
            end
        end
        check("n_results", got_ch.size(), k);
        check("n_conversions", n_start - s0, k * n);
        $display("[TB] scan mask=%b avg=%0d conversions=%0d results=%0d", mask, avg, n_start - s0, got_ch.size());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, g, s0, held;
        logic busy_any;

        repeat (3) tick();
        check("rst_sample_en", int'(sample_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_outputs", int'({ch_sel, sar_start, res_data, res_ch, overrun, timeout_err}), 0);
        rst_n  = 1'b1;
        cfg_en = 1'b1;
        tick();

        // two channels, no averaging, fixed mid-scale value
        prog_q.push_back(8'h80);
        prog_q.push_back(8'h80);
        run_scan(4'b0101, 0);
        if (got_ch.size() == 2) begin
            check("d1_ch_first", got_ch[0], 0);
            check("d1_data_first", got_data[0], 128);
            check("d1_ch_second", got_ch[1], 2);
            check("d1_data_second", got_data[1], 128);
        end

        // four-way average of 10..13
        prog_q.push_back(10);
        prog_q.push_back(11);
        prog_q.push_back(12);
        prog_q.push_back(13);
        run_scan(4'b0010, 2);
        if (got_ch.size() == 1) begin
            check("d2_ch", got_ch[0], 1);
            check("d2_data", got_data[0], 11);
        end

        for (int i = 0; i < 8; i++) begin
            run_scan(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
        end

        // continuous scan with a stalled consumer
        res_ready   = 1'b0;
        cfg_cont    = 1'b1;
        cfg_ch_mask = 4'b0001;
        cfg_avg_log2 = 2'd0;
        conv_vals.delete();
        s0 = n_done;
        pulse_trig();
        g = 0;
        while (n_done < s0 + 1 && g < 500) begin @(negedge clk); g++; end
        repeat (2) @(negedge clk);
        check("ovr_first_valid", int'(res_valid), 1);
        check("ovr_first_flag", int'(overrun), 0);
        if (conv_vals.size() > 0) check("ovr_first_data", int'(res_data), conv_vals[0]);
        g = 0;
        while (n_done < s0 + 2 && g < 500) begin @(negedge clk); g++; end
        repeat (2) @(negedge clk);
        check("ovr_second_flag", int'(overrun), 1);
        if (conv_vals.size() > 1) check("ovr_latest_data", int'(res_data), conv_vals[1]);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        cfg_en  = 1'b0;
        check("ovr_cleared", int'(overrun), 0);
        repeat (10) @(negedge clk);
        check("ovr_stop_busy", int'(busy), 0);
        check("ovr_held_valid", int'(res_valid), 1);
        check("ovr_conv_count", conv_vals.size(), 2);
        if (conv_vals.size() > 1) check("ovr_held_data", int'(res_data), conv_vals[1]);
        $display("[TB] overrun scan conversions=%0d", conv_vals.size());
        cfg_en    = 1'b1;
        cfg_cont  = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("ovr_drained", int'(res_valid), 0);
        tick();

        // core never answers
        core_hang = 1'b1;
        cfg_ch_mask = 4'b0001;
        s0 = n_start;
        pulse_trig();
        wait_start(lat);
        check("to_start_seen", int'(sar_start), 1);
        repeat (TIMEOUT) tick();
        check("to_err_before", int'(timeout_err), 0);
        check("to_busy_before", int'(busy), 1);
        tick();
        check("to_err_set", int'(timeout_err), 1);
        check("to_idle", int'(busy), 0);
        check("to_no_valid", int'(res_valid), 0);
        repeat (5) tick();
        check("to_one_start", n_start - s0, 1);
        $display("[TB] timeout scan starts=%0d timeout_err=%0d", n_start - s0, timeout_err);

        // leave a result pending, then abort a conversion with cfg_en
        core_hang = 1'b0;
        res_ready = 1'b0;
        conv_vals.delete();
        pulse_trig();
        check("to_cleared_by_trig", int'(timeout_err), 0);
        g = 0;
        while (busy && g < 500) begin tick(); g++; end
        tick();
        check("en_pending_valid", int'(res_valid), 1);
        held = (conv_vals.size() > 0) ? conv_vals[0] : -1;
        check("en_pending_data", int'(res_data), held);
        core_hang = 1'b1;
        s0 = n_start;
        pulse_trig();
        wait_start(lat);
        tick();
        cfg_en = 1'b0;
        tick();
        check("en_drop_idle", int'(busy), 0);
        check("en_drop_sample_en", int'(sample_en), 0);
        check("en_drop_valid_kept", int'(res_valid), 1);
        check("en_drop_data_kept", int'(res_data), held);
        repeat (20) tick();
        check("en_drop_no_restart", n_start - s0, 1);
        $display("[TB] cfg_en abort starts=%0d held=%0d", n_start - s0, held);
        cfg_en    = 1'b1;
        core_hang = 1'b0;
        res_ready = 1'b1;
        repeat (2) tick();

        // ignored triggers: empty mask, then sequencer disabled
        s0 = n_start;
        busy_any = 1'b0;
        cfg_ch_mask = '0;
        pulse_trig();
        repeat (10) begin busy_any |= busy; tick(); end
        cfg_en = 1'b0;
        cfg_ch_mask = 4'b0001;
        pulse_trig();
        repeat (10) begin busy_any |= busy; tick(); end
        cfg_en = 1'b1;
        check("ign_busy", int'(busy_any), 0);
        check("ign_no_start", n_start - s0, 0);
        $display("[TB] ignored triggers starts=%0d", n_start - s0);

        // reset in the middle of SAMPLE
        cfg_ch_mask = 4'b0100;
        pulse_trig();
        tick();
        check("rst_mid_sampling", int'(sample_en), 1);
        check("rst_mid_ch_sel", int'(ch_sel), 2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              int'({sample_en, ch_sel, sar_start, res_valid, res_data, res_ch, busy, overrun, timeout_err}), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("rst_mid_after_busy", int'(busy), 0);
        $display("[TB] reset mid-sample done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
